// File: rtl/yolo_pkg.sv
// Shared FP32 types and the raw-bit max rule used by every pooling layer.
package yolo_pkg;

  localparam int FP32_WIDTH = 32;

  typedef logic [FP32_WIDTH-1:0] fp32_t;

  // Sign-magnitude ordering on raw bits; +0 beats -0, equal bits return a.
  function automatic fp32_t fp32_max(input fp32_t a, input fp32_t b);
    fp32_t r;
    if (a == b) begin
      r = a;
    end else if (a[31] != b[31]) begin
      r = a[31] ? b : a;
    end else if (!a[31]) begin
      r = (b[30:0] > a[30:0]) ? b : a;
    end else begin
      r = (b[30:0] < a[30:0]) ? b : a;
    end
    return r;
  endfunction

endpackage

// File: rtl/fp32_max_cmp.sv
// Combinational 2-input FP32 max; zero latency, no flow control.
module fp32_max_cmp
  import yolo_pkg::*;
(
  input  logic [FP32_WIDTH-1:0] a,
  input  logic [FP32_WIDTH-1:0] b,
  output logic [FP32_WIDTH-1:0] y
);

  assign y = fp32_max(a, b);

endmodule

// File: rtl/layer_0_maxpool_2x2.sv
// 2x2 stride-2 FP32 max-pool on a raster stream; valid_out one cycle after each window's last pixel, no backpressure.
// Defining MAXPOOL_FRAME_DONE_EN adds a frame_done pulse alongside the last pooled pixel of each frame.
module layer_0_maxpool_2x2
  import yolo_pkg::*;
#(
  parameter int DATA_WIDTH = FP32_WIDTH,
  parameter int IMG_SIZE   = 416
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out
`ifdef MAXPOOL_FRAME_DONE_EN
  ,
  output logic                  frame_done
`endif
);

  localparam int CW   = (IMG_SIZE > 2) ? $clog2(IMG_SIZE) : 1;
  localparam int HALF = IMG_SIZE / 2;
  localparam int AW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CW-1:0] LAST = CW'(IMG_SIZE - 1);

  logic [CW-1:0] col_cnt;
  logic [CW-1:0] row_cnt;
  logic [AW-1:0] lb_addr;
  logic          col_odd;
  logic          row_odd;
  fp32_t         pair_reg;
  fp32_t         lb_rd;
  fp32_t         h_max;
  fp32_t         v_max;
  fp32_t         linebuf [HALF];

  assign col_odd = col_cnt[0];
  assign row_odd = row_cnt[0];
  assign lb_addr = AW'(col_cnt >> 1);

  fp32_max_cmp u_h_max (
    .a (pair_reg),
    .b (data_in),
    .y (h_max)
  );

  fp32_max_cmp u_v_max (
    .a (h_max),
    .b (lb_rd),
    .y (v_max)
  );

  // Odd rows prefetch the top-row pair max on the even column, so the RAM
  // sees a single registered read per window and never a same-cycle write.
  always_ff @(posedge Clk) begin
    if (valid_in && col_odd && !row_odd) begin
      linebuf[lb_addr] <= h_max;
    end
    if (valid_in && !col_odd && row_odd) begin
      lb_rd <= linebuf[lb_addr];
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      col_cnt   <= '0;
      row_cnt   <= '0;
      pair_reg  <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      if (valid_in) begin
        if (col_cnt == LAST) begin
          col_cnt <= '0;
          row_cnt <= (row_cnt == LAST) ? '0 : row_cnt + 1'b1;
        end else begin
          col_cnt <= col_cnt + 1'b1;
        end
        if (!col_odd) begin
          pair_reg <= data_in;
        end
        if (col_odd && row_odd) begin
          data_out  <= v_max;
          valid_out <= 1'b1;
        end
      end
    end
  end

`ifdef MAXPOOL_FRAME_DONE_EN
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      frame_done <= 1'b0;
    end else begin
      frame_done <= valid_in && (col_cnt == LAST) && (row_cnt == LAST);
    end
  end
`endif

endmodule

// File: tb/tb_layer_0_maxpool_2x2.sv
// Directed bench for layer_0_maxpool_2x2 (4x4 frames) plus a random 8x8 instance against a reference model.
module tb_layer_0_maxpool_2x2;

  localparam int IMG  = 4;
  localparam int IMG2 = 8;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [31:0] data_in, data_out, data_in2, data_out2;
  logic        valid_in, valid_out, valid_in2, valid_out2;
`ifdef MAXPOOL_FRAME_DONE_EN
  logic        frame_done, frame_done2;
`endif

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  logic [31:0] oq[$];
  int          tq[$];
  logic        fq[$];
  logic [31:0] oq2[$];
  logic [31:0] ev[$];
  logic [31:0] frm[16];
  int          pix_cyc[16];
  logic [31:0] rnd[64];

  logic [31:0] pos_tbl[16] = '{
    32'h3f800000, 32'h40000000, 32'h40400000, 32'h40800000,
    32'h40a00000, 32'h40c00000, 32'h40e00000, 32'h41000000,
    32'h41100000, 32'h41200000, 32'h41300000, 32'h41400000,
    32'h41500000, 32'h41600000, 32'h41700000, 32'h41800000};

  layer_0_maxpool_2x2 #(.DATA_WIDTH(32), .IMG_SIZE(IMG)) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .data_out  (data_out),
    .valid_out (valid_out)
`ifdef MAXPOOL_FRAME_DONE_EN
    ,
    .frame_done(frame_done)
`endif
  );

  layer_0_maxpool_2x2 #(.DATA_WIDTH(32), .IMG_SIZE(IMG2)) dut8 (
    .Clk       (Clk),
    .Rst       (Rst),
    .data_in   (data_in2),
    .valid_in  (valid_in2),
    .data_out  (data_out2),
    .valid_out (valid_out2)
`ifdef MAXPOOL_FRAME_DONE_EN
    ,
    .frame_done(frame_done2)
`endif
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  always @(negedge Clk) begin
    if (valid_out) begin
      oq.push_back(data_out);
      tq.push_back(cyc);
`ifdef MAXPOOL_FRAME_DONE_EN
      fq.push_back(frame_done);
`endif
    end
    if (valid_out2) oq2.push_back(data_out2);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic send_frame(input int maxgap);
    for (int k = 0; k < 16; k++) begin
      data_in  = frm[k];
      valid_in = 1'b1;
      @(posedge Clk);
      #1;
      valid_in   = 1'b0;
      pix_cyc[k] = cyc;
      idle($urandom_range(maxgap, 0));
    end
  endtask

  task automatic clear_q();
    oq.delete();
    tq.delete();
    fq.delete();
  endtask

  task automatic push4(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c, input logic [31:0] d);
    ev.push_back(a);
    ev.push_back(b);
    ev.push_back(c);
    ev.push_back(d);
  endtask

  task automatic expect_n(input string tag);
    check({tag, "_cnt"}, 32'(oq.size()), 32'(ev.size()));
    for (int i = 0; i < ev.size(); i++) begin
      check($sformatf("%s_px%0d", tag, i), (i < oq.size()) ? oq[i] : 32'hdeadbeef, ev[i]);
`ifdef MAXPOOL_FRAME_DONE_EN
      check($sformatf("%s_fd%0d", tag, i), (i < fq.size()) ? 32'(fq[i]) : 32'hdeadbeef,
            32'(i % 4 == 3));
`endif
    end
    ev.delete();
    clear_q();
  endtask

  function automatic logic [31:0] okey(input logic [31:0] x);
    return x[31] ? ~x : (x | 32'h80000000);
  endfunction

  function automatic logic [31:0] ref_max(input logic [31:0] a, input logic [31:0] b);
    return (okey(b) > okey(a)) ? b : a;
  endfunction

  initial begin
    int lat_idx[4] = '{5, 7, 13, 15};
    Rst = 1'b1; valid_in = 1'b0; data_in = '0; valid_in2 = 1'b0; data_in2 = '0;

    @(negedge Clk);
    check("rst_dout", data_out, 32'h0);
    check("rst_vld", 32'(valid_out), 32'h0);
`ifdef MAXPOOL_FRAME_DONE_EN
    check("rst_fd", 32'(frame_done), 32'h0);
`endif
    @(posedge Clk);
    #1 Rst = 1'b0;
    idle(1);

    // positive ramp, back-to-back, with latency per output
    for (int k = 0; k < 16; k++) frm[k] = pos_tbl[k];
    send_frame(0);
    idle(3);
    for (int i = 0; i < 4; i++)
      check($sformatf("t1_lat%0d", i), (i < tq.size()) ? 32'(tq[i]) : 32'hdeadbeef,
            32'(pix_cyc[lat_idx[i]]));
    check("t1_hold", data_out, 32'h41800000);
    push4(32'h40c00000, 32'h41000000, 32'h41600000, 32'h41800000);
    expect_n("t1");

    // all-negative ramp
    for (int k = 0; k < 16; k++) frm[k] = pos_tbl[k] | 32'h80000000;
    send_frame(0);
    idle(3);
    push4(32'hbf800000, 32'hc0400000, 32'hc1100000, 32'hc1300000);
    expect_n("t2");

    // signed zeros: +0 in top-left of window 0 and bottom-right of window 3
    for (int k = 0; k < 16; k++) frm[k] = 32'h80000000;
    frm[0]  = 32'h0;
    frm[15] = 32'h0;
    send_frame(0);
    idle(3);
    push4(32'h00000000, 32'h80000000, 32'h80000000, 32'h00000000);
    expect_n("t2z");

    // mixed signs: even-valued pixels negative, max not in bottom-right
    for (int k = 0; k < 16; k++) frm[k] = (k % 2 == 1) ? (pos_tbl[k] | 32'h80000000) : pos_tbl[k];
    send_frame(0);
    idle(3);
    push4(32'h40a00000, 32'h40e00000, 32'h41500000, 32'h41700000);
    expect_n("tmix");

    // random 0-3 cycle bubbles between pixels
    for (int k = 0; k < 16; k++) frm[k] = pos_tbl[k];
    send_frame(3);
    idle(3);
    push4(32'h40c00000, 32'h41000000, 32'h41600000, 32'h41800000);
    expect_n("t3");

    // reset after pixel 7, then a clean frame
    for (int k = 0; k < 7; k++) begin
      data_in  = pos_tbl[k];
      valid_in = 1'b1;
      @(posedge Clk);
      #1;
      valid_in = 1'b0;
    end
    idle(1);
    clear_q();
    Rst = 1'b1;
    @(negedge Clk);
    check("t4_rst_vld", 32'(valid_out), 32'h0);
    check("t4_rst_dout", data_out, 32'h0);
    @(posedge Clk);
    #1 Rst = 1'b0;
    idle(3);
    check("t4_quiet", 32'(oq.size()), 32'h0);
    send_frame(0);
    idle(3);
    push4(32'h40c00000, 32'h41000000, 32'h41600000, 32'h41800000);
    expect_n("t4");

    // two frames back-to-back, second one offset by +100
    send_frame(0);
    for (int k = 0; k < 16; k++) frm[k] = 32'h42800000 + 32'((36 + k + 1) * 32'h20000);
    send_frame(0);
    idle(3);
    push4(32'h40c00000, 32'h41000000, 32'h41600000, 32'h41800000);
    push4(32'h42d40000, 32'h42d80000, 32'h42e40000, 32'h42e80000);
    expect_n("t5");

    // 8x8 random finite frames against a window model, second one with bubbles
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k < 64; k++)
        rnd[k] = {1'($urandom_range(1, 0)), 8'($urandom_range(254, 1)), 23'($urandom)};
      rnd[9] = rnd[8];
      rnd[18] = rnd[19] ^ 32'h80000000;
      for (int k = 0; k < 64; k++) begin
        data_in2  = rnd[k];
        valid_in2 = 1'b1;
        @(posedge Clk);
        #1;
        valid_in2 = 1'b0;
        idle((f == 1) ? $urandom_range(2, 0) : 0);
      end
      idle(3);
      check($sformatf("t6_f%0d_cnt", f), 32'(oq2.size()), 32'd16);
      for (int wr = 0; wr < 4; wr++) begin
        for (int wc = 0; wc < 4; wc++) begin
          int b = (2 * wr) * IMG2 + 2 * wc;
          logic [31:0] m;
          int w = wr * 4 + wc;
          m = ref_max(ref_max(rnd[b], rnd[b + 1]), ref_max(rnd[b + IMG2], rnd[b + IMG2 + 1]));
          check($sformatf("t6_f%0d_w%0d", f, w), (w < oq2.size()) ? oq2[w] : 32'hdeadbeef, m);
        end
      end
      oq2.delete();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
